feed_arbiter: RTL and testbench

Multi-channel, sequence-ordered feed arbiter: accepts messages from NUM_CH redundant feed lines, forwards each sequence number once, in order of first arrival, and drops duplicates and stale messages. Sequence comparison tolerates counter wrap-around. Forwarded messages are buffered in an output FIFO with valid/ready backpressure. Sits between the line receivers and the book-building logic.

---
 rtl/feed_pkg.sv | 33 +++
 rtl/feed_fifo.sv | 52 +++++
 rtl/feed_arbiter.sv | 171 +++++++++++++++++
 tb/tb_feed_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feed_pkg.sv
// Shared types and wrap-aware sequence helpers for the feed arbiter.
// Default widths match the standard two-line, 16-bit-sequence build.
package feed_pkg;

  localparam int unsigned NUM_CH_DEF = 2;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned SEQ_W_DEF  = 16;
  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned CH_W_DEF   = (NUM_CH_DEF > 1) ? $clog2(NUM_CH_DEF) : 1;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [SEQ_W_DEF-1:0]  seq;
    logic [CH_W_DEF-1:0]   ch;
  } feed_entry_t;

  // (seq - last) mod 2^w, returned zero-extended to 32 bits
  function automatic logic [31:0] seq_diff(input logic [31:0] seq,
                                           input logic [31:0] last,
                                           input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (seq - last) & mask;
  endfunction

  // Newer means a non-zero forward distance of less than half the sequence space
  function automatic logic seq_newer(input logic [31:0] diff,
                                     input int unsigned w);
    return (diff != 32'd0) && !diff[5'(w - 1)];
  endfunction

endpackage

// File: rtl/feed_fifo.sv
// Show-ahead output FIFO; head is presented combinationally and reads zero when empty.
module feed_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW + 1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/feed_arbiter.sv
// Redundant-feed arbiter: round-robin grant, wrap-aware dedup, ordered output FIFO.
// Define FEED_STATS_EN to add the drop_cnt/gap_cnt statistics ports and counters.
module feed_arbiter
  import feed_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SEQ_W  = SEQ_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
`ifdef FEED_STATS_EN
  , parameter int unsigned CNT_W = CNT_W_DEF
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH*SEQ_W-1:0]  in_seq,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [CH_W-1:0]          out_ch,
  output logic                     gap_pulse
`ifdef FEED_STATS_EN
  ,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         gap_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEQ_W-1:0]  seq;
    logic [CH_W-1:0]   ch;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  logic [CH_W-1:0]    rr_q, rr_d;
  logic [SEQ_W-1:0]   last_seq_q, last_seq_d;
  logic               first_q, first_d;
  logic               gap_pulse_q, gap_pulse_d;

  logic               fifo_full, fifo_empty;
  logic               grant_vld_c;
  logic [CH_W-1:0]    grant_idx_c;
  logic [SEQ_W-1:0]   grant_seq_c;
  logic [DATA_W-1:0]  grant_data_c;
  logic [31:0]        diff_c;
  logic               accept_c, gap_c;
  entry_t             push_entry, head_entry;
  logic [ENTRY_W-1:0] head_vec;

  logic [SEQ_W-1:0]   seq_arr  [NUM_CH];
  logic [DATA_W-1:0]  data_arr [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign seq_arr[i]  = in_seq[i*SEQ_W +: SEQ_W];
    assign data_arr[i] = in_data[i*DATA_W +: DATA_W];
  end

  // Round-robin search starting at the pointer; no grant while full or in reset
  always_comb begin
    int unsigned c;
    c           = 0;
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      c = (32'(rr_q) + k) % NUM_CH;
      if (!grant_vld_c && in_valid[CH_W'(c)] && !fifo_full && !reset) begin
        grant_vld_c = 1'b1;
        grant_idx_c = CH_W'(c);
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (grant_vld_c) in_ready[grant_idx_c] = 1'b1;
  end

  assign grant_seq_c  = seq_arr[grant_idx_c];
  assign grant_data_c = data_arr[grant_idx_c];

  assign diff_c   = seq_diff(32'(grant_seq_c), 32'(last_seq_q), SEQ_W);
  assign accept_c = grant_vld_c && (first_q || seq_newer(diff_c, SEQ_W));
  assign gap_c    = accept_c && !first_q && (diff_c != 32'd1);

  always_comb begin
    rr_d        = rr_q;
    last_seq_d  = last_seq_q;
    first_d     = first_q;
    gap_pulse_d = gap_c;
    if (grant_vld_c) rr_d = CH_W'((32'(grant_idx_c) + 32'd1) % NUM_CH);
    if (accept_c) begin
      last_seq_d = grant_seq_c;
      first_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q        <= '0;
      last_seq_q  <= '0;
      first_q     <= 1'b1;
      gap_pulse_q <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      last_seq_q  <= last_seq_d;
      first_q     <= first_d;
      gap_pulse_q <= gap_pulse_d;
    end
  end

  assign gap_pulse = gap_pulse_q;

  assign push_entry = '{data: grant_data_c, seq: grant_seq_c, ch: grant_idx_c};

  feed_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (accept_c),
    .din_i   (push_entry),
    .pop_i   (out_ready),
    .dout_o  (head_vec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_entry = head_vec;
  assign out_valid  = !fifo_empty;
  assign out_data   = head_entry.data;
  assign out_seq    = head_entry.seq;
  assign out_ch     = head_entry.ch;

`ifdef FEED_STATS_EN
  logic             drop_c;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;

  assign drop_c = grant_vld_c && !accept_c;

  // Saturating event counters
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    if (drop_c && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    if (gap_c && (gap_cnt_q != '1))   gap_cnt_d  = gap_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign gap_cnt  = gap_cnt_q;
`endif

endmodule

// File: tb/tb_feed_arbiter.sv
// Randomised and directed bench for feed_arbiter against a queue-based reference model.
`timescale 1ns/1ps
module tb_feed_arbiter;

  localparam int N   = 2;
  localparam int DW  = 32;
  localparam int SW  = 16;
  localparam int D   = 8;
  localparam int CHW = 1;
  localparam int CW  = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data;
  logic [N*SW-1:0] in_seq;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_seq;
  logic [CHW-1:0]  out_ch;
  logic            gap_pulse;
`ifdef FEED_STATS_EN
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   gap_cnt;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] seq;
    int            ch;
  } msg_t;

  msg_t          mq[$];
  bit            m_first;
  logic [SW-1:0] m_last;
  int            m_rr;
  bit            m_gap;
  int            m_drops;
  int            m_gaps;
  int            last_grant;
  int            n_vec;
  int            n_err;

  always #5 clk = ~clk;

  feed_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_seq    (in_seq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_seq   (out_seq),
    .out_ch    (out_ch),
    .gap_pulse (gap_pulse)
`ifdef FEED_STATS_EN
    ,
    .drop_cnt  (drop_cnt),
    .gap_cnt   (gap_cnt)
`endif
  );

  task automatic set_ch(input int ch, input logic v, input logic [SW-1:0] s, input logic [DW-1:0] d);
    in_valid[ch]         = v;
    in_seq[ch*SW +: SW]  = s;
    in_data[ch*DW +: DW] = d;
  endtask

  // Compare DUT against the model for this cycle, then advance both through one clock
  task automatic cycle();
    logic [N-1:0]  exp_rdy;
    logic [SW-1:0] s;
    logic [SW-1:0] diff;
    int            g;
    int            c;
    msg_t          m;
    bit            new_gap;
    #1;
    exp_rdy = '0;
    g       = -1;
    if (mq.size() < D) begin
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (g < 0 && in_valid[c]) g = c;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;

    n_vec++;
    if (in_ready !== exp_rdy) begin
      n_err++; $display("FAIL in_ready: got %b want %b", in_ready, exp_rdy);
    end
    n_vec++;
    if (out_valid !== (mq.size() > 0)) begin
      n_err++; $display("FAIL out_valid: got %b want %b", out_valid, mq.size() > 0);
    end
    if (mq.size() > 0) begin
      n_vec++;
      if (out_seq !== mq[0].seq || out_data !== mq[0].data || out_ch !== CHW'(mq[0].ch)) begin
        n_err++;
        $display("FAIL head: got seq %h data %h ch %0d want seq %h data %h ch %0d",
                 out_seq, out_data, out_ch, mq[0].seq, mq[0].data, mq[0].ch);
      end
    end
    n_vec++;
    if (gap_pulse !== m_gap) begin
      n_err++; $display("FAIL gap_pulse: got %b want %b", gap_pulse, m_gap);
    end
`ifdef FEED_STATS_EN
    n_vec++;
    if (drop_cnt !== CW'(m_drops) || gap_cnt !== CW'(m_gaps)) begin
      n_err++; $display("FAIL counters: got drop %0d gap %0d want drop %0d gap %0d",
                        drop_cnt, gap_cnt, m_drops, m_gaps);
    end
`endif

    if (out_ready && mq.size() > 0) void'(mq.pop_front());
    new_gap = 1'b0;
    if (g >= 0) begin
      s    = in_seq[g*SW +: SW];
      diff = s - m_last;
      if (m_first || (diff != 0 && diff < 16'h8000)) begin
        m.data = in_data[g*DW +: DW];
        m.seq  = s;
        m.ch   = g;
        mq.push_back(m);
        if (!m_first && diff != 16'd1) begin
          new_gap = 1'b1;
          if (m_gaps < 65535) m_gaps++;
        end
        m_last  = s;
        m_first = 1'b0;
      end else if (m_drops < 65535) begin
        m_drops++;
      end
      m_rr = (g + 1) % N;
    end
    m_gap      = new_gap;
    last_grant = g;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    mq.delete();
    m_first = 1'b1;
    m_last  = '0;
    m_rr    = 0;
    m_gap   = 1'b0;
    m_drops = 0;
    m_gaps  = 0;
  endtask

  task automatic drain();
    int budget;
    in_valid  = '0;
    out_ready = 1'b1;
    budget    = 0;
    while (mq.size() > 0 && budget < 40) begin
      cycle();
      budget++;
    end
    n_vec++;
    if (mq.size() > 0) begin
      n_err++; $display("FAIL drain_timeout: %0d entries left want 0", mq.size());
    end
    cycle();
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = '1;
    in_seq   = '0;
    in_data  = '0;
    #1;
    n_vec++;
    if (in_ready !== '0) begin
      n_err++; $display("FAIL reset_in_ready: got %b want 00", in_ready);
    end
    apply_reset();
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_seq !== '0 || out_ch !== '0 || gap_pulse !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs: got v %b d %h s %h ch %0d gap %b want all zero",
                        out_valid, out_data, out_seq, out_ch, gap_pulse);
    end
`ifdef FEED_STATS_EN
    n_vec++;
    if (drop_cnt !== '0 || gap_cnt !== '0) begin
      n_err++; $display("FAIL reset_counters: got %0d %0d want 0 0", drop_cnt, gap_cnt);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_in_order();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ch(0, 1'b1, SW'(5 + i), $urandom);
      cycle();
    end
    drain();
  endtask

  task automatic test_same_seq();
    apply_reset();
    out_ready = 1'b1;
    set_ch(0, 1'b1, 16'd10, 32'hA0A0_0000);
    set_ch(1, 1'b1, 16'd10, 32'hB1B1_0001);
    cycle();
    n_vec++;
    if (last_grant != 0) begin
      n_err++; $display("FAIL same_seq_first_grant: got ch %0d want 0", last_grant);
    end
    cycle();
    drain();
`ifdef FEED_STATS_EN
    n_vec++;
    if (drop_cnt !== CW'(1)) begin
      n_err++; $display("FAIL same_seq_drops: got %0d want 1", drop_cnt);
    end
`endif
  endtask

  task automatic test_gap();
    apply_reset();
    out_ready = 1'b1;
    set_ch(1, 1'b1, 16'd20, $urandom);
    cycle();
    set_ch(1, 1'b1, 16'd23, $urandom);
    cycle();
    in_valid = '0;
    #1;
    n_vec++;
    if (gap_pulse !== 1'b1) begin
      n_err++; $display("FAIL gap_seen: got %b want 1", gap_pulse);
    end
    cycle();
    drain();
  endtask

  task automatic test_wrap();
    logic [SW-1:0] seqs [4];
    seqs[0] = 16'hFFFE; seqs[1] = 16'hFFFF; seqs[2] = 16'h0000; seqs[3] = 16'hFFF0;
    apply_reset();
    out_ready = 1'b1;
    in_valid  = '0;
    for (int i = 0; i < 4; i++) begin
      set_ch(i % N, 1'b1, seqs[i], $urandom);
      set_ch((i + 1) % N, 1'b0, '0, '0);
      cycle();
    end
    drain();
  endtask

  task automatic test_full();
    int sent;
    int budget;
    apply_reset();
    out_ready = 1'b0;
    sent      = 0;
    budget    = 0;
    while (sent < 9 && budget < 60) begin
      if (budget == 20) out_ready = 1'b1;
      set_ch(0, 1'b1, SW'(100 + sent), $urandom);
      cycle();
      if (last_grant == 0) sent++;
      budget++;
    end
    n_vec++;
    if (sent != 9) begin
      n_err++; $display("FAIL full_accepts: got %0d want 9", sent);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ch(1, 1'b1, SW'(40 + 2 * i), $urandom);
      cycle();
    end
    apply_reset();
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_valid: got %b want 0", out_valid);
    end
`ifdef FEED_STATS_EN
    n_vec++;
    if (drop_cnt !== '0 || gap_cnt !== '0) begin
      n_err++; $display("FAIL reset_mid_counters: got %0d %0d want 0 0", drop_cnt, gap_cnt);
    end
`endif
    @(negedge clk);
    out_ready = 1'b1;
    set_ch(0, 1'b1, 16'd3, 32'h0000_0003);
    cycle();
    drain();
  endtask

  task automatic test_random();
    logic [SW-1:0] s;
    int            r;
    apply_reset();
    out_ready = 1'b1;
    set_ch(0, 1'b1, 16'hFFF8, $urandom);
    cycle();
    for (int i = 0; i < 1500; i++) begin
      for (int ch = 0; ch < N; ch++) begin
        s = m_last + SW'($urandom_range(0, 6)) - SW'(2);
        r = int'($urandom_range(0, 49));
        if (r == 0) s = s + 16'h4000;
        if (r == 1) s = s + 16'h9000;
        set_ch(ch, 1'($urandom_range(0, 1)), s, $urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    in_valid  = '0;
    in_seq    = '0;
    in_data   = '0;
    out_ready = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    test_reset();
    test_in_order();
    test_same_seq();
    test_gap();
    test_wrap();
    test_full();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
